// File: rtl/compact_mimo_fifo_pkg.sv
// compact_mimo_fifo_pkg
//   Shared constants and types for the compacting multi-in / multi-out FIFO.
//   Holds the default parameter values used by compact_mimo_fifo and
//   lane_compactor, plus the default storage word type.
package compact_mimo_fifo_pkg;

   localparam int DEPTH_DEF      = 32;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int IN_LANES_DEF   = 9;
   localparam int OUT_LANES_DEF  = 4;

   typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage : compact_mimo_fifo_pkg

// File: rtl/lane_compactor.sv
// lane_compactor
//   Turns a sparse lane-valid mask into dense write offsets. Each valid lane
//   gets the number of valid lanes below it (exclusive prefix sum), so valid
//   lanes land in consecutive FIFO slots in ascending lane order.
// Ports
//   valid  : per-lane valid mask (bit k belongs to lane k)
//   offset : per-lane slot offset relative to the write pointer
//   wn     : total number of valid lanes (popcount of valid)
module lane_compactor
   import compact_mimo_fifo_pkg::*;
#(
   parameter int IN_LANES = IN_LANES_DEF,
   parameter int CNT_W    = $clog2(IN_LANES + 1)
) (
   input  logic [IN_LANES-1:0]            valid,
   output logic [0:IN_LANES-1][CNT_W-1:0] offset,
   output logic [CNT_W-1:0]               wn
);

   logic [CNT_W-1:0] run;

   always_comb begin
      run    = '0;
      offset = '0;
      for (int k = 0; k < IN_LANES; k++) begin
         offset[k] = run;
         run       = run + CNT_W'(valid[k]);
      end
      wn = run;
   end

endmodule : lane_compactor

// File: rtl/compact_mimo_fifo.sv
// compact_mimo_fifo
//   Circular FIFO accepting up to IN_LANES sparse words per cycle (valid
//   lanes are compacted) and presenting the OUT_LANES oldest words
//   show-ahead. Writes are all-or-nothing against start-of-cycle free space;
//   pops of 1..min(count,OUT_LANES) words are accepted, anything else ignored.
//   Space freed by a pop only becomes writable on the following cycle.
// Configuration
//   COMPACT_MIMO_FIFO_ERR_EN : when defined, o_overflow/o_underflow are sticky
//   error flags cleared by i_clear or reset; otherwise both are tied to 0.
// Ports
//   i_clk, i_nrst      : clock, asynchronous active-low reset
//   i_clear            : synchronous flush of pointers, count and flags
//   i_write_en         : write request for lanes qualified by i_valid
//   i_data, i_valid    : write lanes and their qualifiers
//   i_pop_en           : pop request of i_pop_count words
//   o_data, o_valid    : oldest words (o_data[0] oldest) and their valids
//   o_count            : occupancy
//   o_empty, o_full    : occupancy status
//   o_write_ready      : at least IN_LANES free slots
//   o_overflow         : sticky, a write was rejected for lack of space
//   o_underflow        : sticky, a pop of an unavailable word count was made
module compact_mimo_fifo
   import compact_mimo_fifo_pkg::*;
#(
   parameter int DEPTH      = DEPTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int IN_LANES   = IN_LANES_DEF,
   parameter int OUT_LANES  = OUT_LANES_DEF,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                                  i_clk,
   input  logic                                  i_nrst,
   input  logic                                  i_clear,
   input  logic                                  i_write_en,
   input  logic [0:IN_LANES-1][DATA_WIDTH-1:0]   i_data,
   input  logic [IN_LANES-1:0]                   i_valid,
   input  logic                                  i_pop_en,
   input  logic [$clog2(OUT_LANES+1)-1:0]        i_pop_count,
   output logic [0:OUT_LANES-1][DATA_WIDTH-1:0]  o_data,
   output logic [OUT_LANES-1:0]                  o_valid,
   output logic [ADDR_WIDTH:0]                   o_count,
   output logic                                  o_empty,
   output logic                                  o_full,
   output logic                                  o_write_ready,
   output logic                                  o_overflow,
   output logic                                  o_underflow
);

   localparam int CNT_W = $clog2(IN_LANES + 1);
   localparam int CW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0]            mem [DEPTH];
   logic [ADDR_WIDTH-1:0]            wr_ptr;
   logic [ADDR_WIDTH-1:0]            rd_ptr;
   logic [CW-1:0]                    count;

   logic [0:IN_LANES-1][CNT_W-1:0]   offset;
   logic [CNT_W-1:0]                 wn;
   logic [31:0]                      free;
   logic                             wr_acc;
   logic                             pop_acc;

   lane_compactor #(
      .IN_LANES (IN_LANES),
      .CNT_W    (CNT_W)
   ) u_lane_compactor (
      .valid  (i_valid),
      .offset (offset),
      .wn     (wn)
   );

   // Accept decisions, both judged on start-of-cycle occupancy
   always_comb begin
      free    = 32'(DEPTH) - 32'(count);
      wr_acc  = i_write_en && (wn != '0) && (32'(wn) <= free);
      pop_acc = i_pop_en && (i_pop_count != '0)
                && (32'(i_pop_count) <= 32'(count))
                && (32'(i_pop_count) <= 32'(OUT_LANES));
   end

   // Pointer and occupancy state
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + ADDR_WIDTH'(wn);
         if (pop_acc)
            rd_ptr <= rd_ptr + ADDR_WIDTH'(i_pop_count);
         count <= CW'(32'(count)
                      + (wr_acc  ? 32'(wn)          : 32'd0)
                      - (pop_acc ? 32'(i_pop_count) : 32'd0));
      end
   end

   // Storage: not reset; a write coinciding with reset or clear is dropped
   always_ff @(posedge i_clk) begin
      if (i_nrst && !i_clear && wr_acc) begin
         for (int k = 0; k < IN_LANES; k++) begin
            if (i_valid[k])
               mem[wr_ptr + ADDR_WIDTH'(offset[k])] <= i_data[k];
         end
      end
   end

   // Show-ahead read window and status
   always_comb begin
      o_valid = '0;
      o_data  = '0;
      for (int j = 0; j < OUT_LANES; j++) begin
         if (32'(j) < 32'(count)) begin
            o_valid[j] = 1'b1;
            o_data[j]  = mem[rd_ptr + ADDR_WIDTH'(j)];
         end
      end
      o_count       = count;
      o_empty       = (count == '0);
      o_full        = (count == CW'(DEPTH));
      o_write_ready = (free >= 32'(IN_LANES));
   end

`ifdef COMPACT_MIMO_FIFO_ERR_EN
   logic wr_rej;
   logic pop_rej;
   logic ovf_q;
   logic udf_q;

   // A write with wn=0 never exceeds free space, so it never flags
   always_comb begin
      wr_rej  = i_write_en && (32'(wn) > free);
      pop_rej = i_pop_en && (i_pop_count != '0) && !pop_acc;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else if (i_clear) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (wr_rej)
            ovf_q <= 1'b1;
         if (pop_rej)
            udf_q <= 1'b1;
      end
   end

   assign o_overflow  = ovf_q;
   assign o_underflow = udf_q;
`else
   assign o_overflow  = 1'b0;
   assign o_underflow = 1'b0;
`endif

endmodule : compact_mimo_fifo

// File: tb/tb_compact_mimo_fifo.sv
// tb_compact_mimo_fifo
//   Self-checking bench for compact_mimo_fifo. A queue-based model tracks the
//   FIFO contents and sticky flags; a negedge process compares every output
//   against it, while directed scenarios pin the model with literal values.
//   Build with or without COMPACT_MIMO_FIFO_ERR_EN to match the RTL.
module tb_compact_mimo_fifo;
   import compact_mimo_fifo_pkg::*;

   localparam int DEPTH = DEPTH_DEF;
   localparam int DW    = DATA_WIDTH_DEF;
   localparam int IN_L  = IN_LANES_DEF;
   localparam int OUT_L = OUT_LANES_DEF;
   localparam int AW    = $clog2(DEPTH);
   localparam int PC_W  = $clog2(OUT_L + 1);

   logic                        clk = 1'b0;
   logic                        i_nrst = 1'b0;
   logic                        i_clear = 1'b0;
   logic                        i_write_en = 1'b0;
   logic [0:IN_L-1][DW-1:0]     i_data = '0;
   logic [IN_L-1:0]             i_valid = '0;
   logic                        i_pop_en = 1'b0;
   logic [PC_W-1:0]             i_pop_count = '0;
   logic [0:OUT_L-1][DW-1:0]    o_data;
   logic [OUT_L-1:0]            o_valid;
   logic [AW:0]                 o_count;
   logic                        o_empty, o_full, o_write_ready;
   logic                        o_overflow, o_underflow;

   int    n_checks = 0;
   int    n_fail   = 0;
   word_t q[$];
   bit    m_ovf = 1'b0;
   bit    m_udf = 1'b0;
   bit    chk_en = 1'b0;
   bit    flags_on;
   int    nxt;
   int    head;

   compact_mimo_fifo dut (
      .i_clk         (clk),
      .i_nrst        (i_nrst),
      .i_clear       (i_clear),
      .i_write_en    (i_write_en),
      .i_data        (i_data),
      .i_valid       (i_valid),
      .i_pop_en      (i_pop_en),
      .i_pop_count   (i_pop_count),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .o_count       (o_count),
      .o_empty       (o_empty),
      .o_full        (o_full),
      .o_write_ready (o_write_ready),
      .o_overflow    (o_overflow),
      .o_underflow   (o_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [OUT_L*DW-1:0] model_data();
      logic [0:OUT_L-1][DW-1:0] d;
      d = '0;
      for (int j = 0; j < OUT_L; j++)
         if (j < q.size()) d[j] = q[j];
      return d;
   endfunction

   function automatic logic [OUT_L-1:0] model_valid();
      logic [OUT_L-1:0] v;
      v = '0;
      for (int j = 0; j < OUT_L; j++)
         v[j] = (j < q.size());
      return v;
   endfunction

   // Abstract FIFO behaviour applied at each active edge
   task automatic model_update();
      int cnt0, wn, pn;
      bit wacc, pacc;
      if (i_clear) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         return;
      end
      cnt0 = q.size();
      wn   = i_write_en ? $countones(i_valid) : 0;
      pn   = int'(i_pop_count);
      wacc = i_write_en && wn > 0 && wn <= DEPTH - cnt0;
      pacc = i_pop_en && pn >= 1 && pn <= cnt0 && pn <= OUT_L;
      if (flags_on) begin
         if (i_write_en && wn > DEPTH - cnt0) m_ovf = 1'b1;
         if (i_pop_en && pn != 0 && !pacc)    m_udf = 1'b1;
      end
      if (pacc)
         for (int i = 0; i < pn; i++) void'(q.pop_front());
      if (wacc)
         for (int k = 0; k < IN_L; k++)
            if (i_valid[k]) q.push_back(i_data[k]);
   endtask

   // Single compare process against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",       o_count, q.size());
         chk("empty",       o_empty, q.size() == 0);
         chk("full",        o_full, q.size() == DEPTH);
         chk("write_ready", o_write_ready, (DEPTH - q.size()) >= IN_L);
         chk("valid",       o_valid, model_valid());
         chk("data",        o_data, model_data());
         chk("overflow",    o_overflow, m_ovf);
         chk("underflow",   o_underflow, m_udf);
      end
   end

   task automatic tick();
      @(posedge clk);
      if (i_nrst) model_update();
      #1;
   endtask

   task automatic idle();
      i_clear     = 1'b0;
      i_write_en  = 1'b0;
      i_valid     = '0;
      i_pop_en    = 1'b0;
      i_pop_count = '0;
   endtask

   task automatic op(input bit we, input logic [IN_L-1:0] vmask,
                     input bit pe, input int pn, input bit clr);
      i_write_en  = we;
      i_valid     = vmask;
      i_pop_en    = pe;
      i_pop_count = PC_W'(pn);
      i_clear     = clr;
      tick();
      idle();
   endtask

   task automatic rand_data();
      for (int k = 0; k < IN_L; k++) i_data[k] = DW'($urandom);
   endtask

   task automatic seq_data();
      for (int k = 0; k < IN_L; k++) i_data[k] = DW'(nxt + k);
   endtask

   task automatic async_reset();
      i_nrst = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      #2;
      chk("rst_count", o_count, 0);
      chk("rst_empty", o_empty, 1'b1);
      chk("rst_valid", o_valid, 4'b0000);
      chk("rst_data",  o_data, 32'h0);
      tick();
      i_nrst = 1'b1;
   endtask

   initial begin
`ifdef COMPACT_MIMO_FIFO_ERR_EN
      flags_on = 1'b1;
`else
      flags_on = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset_empty", o_empty, 1'b1);
      chk("reset_full",  o_full, 1'b0);
      chk("reset_wrdy",  o_write_ready, 1'b1);
      chk("reset_count", o_count, 0);
      chk("reset_flags", {o_overflow, o_underflow}, 2'b00);
      i_nrst = 1'b1;
      tick();

      // Compaction of five valid lanes, then a pop of three
      i_data = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18, 8'h29};
      op(1, 9'b000011111, 0, 0, 0);
      chk("w5_count", o_count, 5);
      chk("w5_data",  o_data, 32'hA1B2C3D4);
      chk("w5_valid", o_valid, 4'b1111);
      op(0, '0, 1, 3, 0);
      chk("p3_data",  o_data, 32'hD4E50000);
      chk("p3_valid", o_valid, 4'b0011);
      chk("p3_count", o_count, 2);

      // Fill to full with an all-or-nothing rejection on the way
      op(0, '0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         rand_data();
         op(1, '1, 0, 0, 0);
      end
      chk("fill_count", o_count, 27);
      chk("fill_wrdy",  o_write_ready, 1'b0);
      rand_data();
      op(1, '1, 0, 0, 0);
      chk("rej_count", o_count, 27);
      chk("rej_ovf",   o_overflow, flags_on);
      rand_data();
      op(1, 9'b000011111, 0, 0, 0);
      chk("full_count", o_count, 32);
      chk("full_flag",  o_full, 1'b1);

      // Simultaneous write and pop, then a steady stream across the wrap
      op(0, '0, 0, 0, 1);
      nxt = 0;
      seq_data();
      op(1, 9'h03F, 0, 0, 0);
      nxt = 6;
      chk("six_count", o_count, 6);
      seq_data();
      op(1, 9'h003, 1, 4, 0);
      nxt = 8;
      chk("wp_count", o_count, 4);
      head = 4;
      chk("wp_head", o_data[0], DW'(head));
      for (int i = 0; i < 30; i++) begin
         seq_data();
         op(1, 9'h003, 1, 2, 0);
         nxt  += 2;
         head += 2;
         chk("wrap_head", o_data[0], DW'(head));
         chk("wrap_next", o_data[1], DW'(head + 1));
      end

      // Underflow, then clear overriding a write
      op(0, '0, 0, 0, 1);
      rand_data();
      op(1, 9'h003, 0, 0, 0);
      op(0, '0, 1, 3, 0);
      chk("uf_count", o_count, 2);
      chk("uf_flag",  o_underflow, flags_on);
      rand_data();
      op(1, '1, 0, 0, 1);
      chk("clr_count", o_count, 0);
      chk("clr_empty", o_empty, 1'b1);
      chk("clr_flags", {o_overflow, o_underflow}, 2'b00);

      // Asynchronous reset with data held
      rand_data();
      op(1, '1, 0, 0, 0);
      async_reset();

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r == 0) begin
            async_reset();
         end else begin
            rand_data();
            i_write_en  = ($urandom_range(0, 2) != 0);
            i_valid     = IN_L'($urandom);
            if ($urandom_range(0, 3) == 0) i_valid = '1;
            i_pop_en    = ($urandom_range(0, 1) != 0);
            i_pop_count = ($urandom_range(0, 9) == 0) ? PC_W'($urandom_range(0, 7))
                                                      : PC_W'($urandom_range(1, OUT_L));
            i_clear     = (r < 3);
            tick();
            idle();
         end
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_compact_mimo_fifo
